// File: rtl/eth_udp_rx_if.sv
// Byte-wide AXI-stream payload bus (no tready).
// Carries UDP payload beats out of the receive parser.
interface eth_udp_rx_if;
  logic [7:0] tdata;
  logic       tvalid;
  logic       tlast;
  logic       tuser;

  modport master (
    output tdata, tvalid, tlast, tuser
  );

  modport slave (
    input tdata, tvalid, tlast, tuser
  );
endinterface

// File: rtl/eth_udp_rx.sv
// Ethernet II / IPv4 / UDP receive parser.
// Filters on MAC/IP/port and streams the UDP payload out.
module eth_udp_rx #(
  parameter int ACCEPT_BROADCAST = 1,
  parameter int MIN_PREAMBLE     = 1
) (
  input  logic                sys_clk,
  input  logic                rst,
  input  logic [47:0]         local_mac,
  input  logic [31:0]         local_ip,
  input  logic [15:0]         local_port,
  input  logic [7:0]          rx_data,
  input  logic                rx_dv,
  eth_udp_rx_if.master        m_axis,
  output logic                hdr_valid,
  output logic [47:0]         src_mac,
  output logic [31:0]         src_ip,
  output logic [15:0]         src_port,
  output logic [15:0]         udp_len,
  output logic                frame_drop
);

  typedef enum logic [2:0] {
    IDLE, PRE, ETH, IP, UDP, PAY, DROP
  } state_t;

  localparam logic [2:0] MIN_PRE = 3'(MIN_PREAMBLE);
  localparam logic BCAST_OK = (ACCEPT_BROADCAST != 0);

  state_t      state, state_n;
  logic [15:0] cnt, cnt_n;
  logic [2:0]  pre_cnt, pre_n;
  logic        bad, commit, beat, last, err;

  // last five bytes seen; with rx_data they form any field
  logic [39:0] sh;
  logic [47:0] mac_t;
  logic [31:0] ip_t;
  logic [15:0] port_t, len_t, pay_len;

  logic [7:0]  tdata_q;
  logic        tvalid_q, tlast_q, tuser_q;

  logic [47:0] dst;
  logic [15:0] w16;
  logic [31:0] w32;
  logic        mac_ok;

  assign dst    = {sh, rx_data};
  assign w16    = {sh[7:0], rx_data};
  assign w32    = {sh[23:0], rx_data};
  assign mac_ok = (dst == local_mac) ||
                  (BCAST_OK && dst == 48'hFFFF_FFFF_FFFF);

  always_comb begin
    state_n = state;
    cnt_n   = cnt + 16'd1;
    pre_n   = pre_cnt;
    bad     = 1'b0;
    commit  = 1'b0;
    beat    = 1'b0;
    last    = 1'b0;
    err     = 1'b0;
    unique case (state)
      IDLE: begin
        cnt_n = '0;
        if (rx_dv) begin
          if (rx_data == 8'h55) begin
            state_n = PRE;
            pre_n   = 3'd1;
          end else begin
            state_n = DROP;
          end
        end
      end
      PRE: begin
        cnt_n = '0;
        if (!rx_dv) begin
          state_n = IDLE;
          bad     = 1'b1;
        end else if (rx_data == 8'h55) begin
          if (pre_cnt != 3'd7) pre_n = pre_cnt + 3'd1;
        end else if (rx_data == 8'hD5 && pre_cnt >= MIN_PRE) begin
          state_n = ETH;
        end else begin
          state_n = DROP;
        end
      end
      ETH: begin
        if (!rx_dv) begin
          state_n = IDLE;
          bad     = 1'b1;
        end else if ((cnt == 16'd5 && !mac_ok) ||
                     (cnt == 16'd13 && w16 != 16'h0800)) begin
          state_n = DROP;
          bad     = 1'b1;
        end else if (cnt == 16'd13) begin
          state_n = IP;
          cnt_n   = '0;
        end
      end
      IP: begin
        if (!rx_dv) begin
          state_n = IDLE;
          bad     = 1'b1;
        end else if ((cnt == 16'd0 && rx_data != 8'h45) ||
                     (cnt == 16'd9 && rx_data != 8'h11) ||
                     (cnt == 16'd19 && w32 != local_ip)) begin
          state_n = DROP;
          bad     = 1'b1;
        end else if (cnt == 16'd19) begin
          state_n = UDP;
          cnt_n   = '0;
        end
      end
      UDP: begin
        if (!rx_dv) begin
          state_n = IDLE;
          bad     = 1'b1;
        end else if ((cnt == 16'd3 && w16 != local_port) ||
                     (cnt == 16'd5 && w16 < 16'd9)) begin
          state_n = DROP;
          bad     = 1'b1;
        end else if (cnt == 16'd7) begin
          state_n = PAY;
          cnt_n   = '0;
          commit  = 1'b1;
        end
      end
      PAY: begin
        if (!rx_dv) begin
          state_n = IDLE;
          err     = 1'b1;
        end else begin
          beat = 1'b1;
          last = (cnt + 16'd1 == pay_len);
          if (last) state_n = DROP;
        end
      end
      DROP: begin
        cnt_n = '0;
        if (!rx_dv) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge sys_clk) begin
    if (rst) begin
      state   <= IDLE;
      cnt     <= '0;
      pre_cnt <= '0;
    end else begin
      state   <= state_n;
      cnt     <= cnt_n;
      pre_cnt <= pre_n;
    end
  end

  always_ff @(posedge sys_clk) begin
    if (rst) begin
      sh         <= '0;
      mac_t      <= '0;
      ip_t       <= '0;
      port_t     <= '0;
      len_t      <= '0;
      pay_len    <= '0;
      tdata_q    <= '0;
      tvalid_q   <= 1'b0;
      tlast_q    <= 1'b0;
      tuser_q    <= 1'b0;
      hdr_valid  <= 1'b0;
      frame_drop <= 1'b0;
      src_mac    <= '0;
      src_ip     <= '0;
      src_port   <= '0;
      udp_len    <= '0;
    end else begin
      sh         <= {sh[31:0], rx_data};
      frame_drop <= bad;
      hdr_valid  <= commit;
      tvalid_q   <= beat | err;
      tlast_q    <= last | err;
      tuser_q    <= err;
      if (beat)     tdata_q <= rx_data;
      else if (err) tdata_q <= 8'h00;
      if (state == ETH && cnt == 16'd11) mac_t  <= dst;
      if (state == IP  && cnt == 16'd15) ip_t   <= w32;
      if (state == UDP && cnt == 16'd1)  port_t <= w16;
      if (state == UDP && cnt == 16'd5)  len_t  <= w16;
      if (commit) begin
        src_mac  <= mac_t;
        src_ip   <= ip_t;
        src_port <= port_t;
        udp_len  <= len_t;
        pay_len  <= len_t - 16'd8;
      end
    end
  end

  assign m_axis.tdata  = tdata_q;
  assign m_axis.tvalid = tvalid_q;
  assign m_axis.tlast  = tlast_q;
  assign m_axis.tuser  = tuser_q;

endmodule

// File: tb/tb_eth_udp_rx.sv
// Scoreboard bench for eth_udp_rx.
// Frames are built byte-by-byte; expected beats queued up front.
module tb_eth_udp_rx;

  localparam logic [47:0] LMAC  = 48'h02_00_00_00_00_01;
  localparam logic [31:0] LIP   = 32'hC0A8_010A;
  localparam logic [15:0] LPORT = 16'h1234;
  localparam logic [47:0] SMAC  = 48'h02_AA_BB_CC_DD_EE;
  localparam logic [31:0] SIP   = 32'hC0A8_0105;
  localparam logic [15:0] SPORT = 16'hBEEF;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [47:0] local_mac = LMAC;
  logic [31:0] local_ip = LIP;
  logic [15:0] local_port = LPORT;
  logic [7:0]  rx_data = 8'h00;
  logic        rx_dv = 1'b0;
  logic        hdr_valid, frame_drop;
  logic [47:0] src_mac;
  logic [31:0] src_ip;
  logic [15:0] src_port, udp_len;

  eth_udp_rx_if axis ();

  eth_udp_rx #(
    .ACCEPT_BROADCAST(1),
    .MIN_PREAMBLE(1)
  ) dut (
    .sys_clk(clk),
    .rst(rst),
    .local_mac(local_mac),
    .local_ip(local_ip),
    .local_port(local_port),
    .rx_data(rx_data),
    .rx_dv(rx_dv),
    .m_axis(axis),
    .hdr_valid(hdr_valid),
    .src_mac(src_mac),
    .src_ip(src_ip),
    .src_port(src_port),
    .udp_len(udp_len),
    .frame_drop(frame_drop)
  );

  always #5 clk = ~clk;

  logic [7:0]  frm[$];
  logic [7:0]  pay[$];
  logic [9:0]  sb[$];
  logic [15:0] exp_len;

  int n_checks = 0, n_fail = 0;
  int m_checks = 0, m_fail = 0;
  int hdr_cnt = 0, drop_cnt = 0;

  always @(negedge clk) begin
    if (axis.tvalid) begin
      m_checks++;
      if (sb.size() == 0) begin
        m_fail++;
        $display("FAIL beat_unexpected got=%h last=%b user=%b",
                 axis.tdata, axis.tlast, axis.tuser);
      end else begin
        logic [9:0] e;
        e = sb.pop_front();
        if ({axis.tdata, axis.tlast, axis.tuser} !== e) begin
          m_fail++;
          $display("FAIL beat got=%h/%b/%b exp=%h/%b/%b",
                   axis.tdata, axis.tlast, axis.tuser,
                   e[9:2], e[1], e[0]);
        end
      end
    end
    if (hdr_valid) begin
      hdr_cnt++;
      m_checks++;
      if ({src_mac, src_ip, src_port, udp_len} !==
          {SMAC, SIP, SPORT, exp_len}) begin
        m_fail++;
        $display("FAIL hdr got=%h %h %h %h exp=%h %h %h %h",
                 src_mac, src_ip, src_port, udp_len,
                 SMAC, SIP, SPORT, exp_len);
      end
    end
    if (frame_drop) drop_cnt++;
  end

  task automatic build(input logic [47:0] dmac,
                       input logic [15:0] etype,
                       input logic [31:0] dip,
                       input logic [15:0] ulen,
                       input int npad);
    logic [15:0] tot;
    tot = ulen + 16'd20;
    frm.delete();
    repeat (7) frm.push_back(8'h55);
    frm.push_back(8'hD5);
    for (int i = 5; i >= 0; i--) frm.push_back(dmac[i*8 +: 8]);
    for (int i = 5; i >= 0; i--) frm.push_back(SMAC[i*8 +: 8]);
    frm.push_back(etype[15:8]);
    frm.push_back(etype[7:0]);
    frm.push_back(8'h45);
    frm.push_back(8'h00);
    frm.push_back(tot[15:8]);
    frm.push_back(tot[7:0]);
    repeat (4) frm.push_back(8'h00);
    frm.push_back(8'h40);
    frm.push_back(8'h11);
    repeat (2) frm.push_back(8'h00);
    for (int i = 3; i >= 0; i--) frm.push_back(SIP[i*8 +: 8]);
    for (int i = 3; i >= 0; i--) frm.push_back(dip[i*8 +: 8]);
    frm.push_back(SPORT[15:8]);
    frm.push_back(SPORT[7:0]);
    frm.push_back(LPORT[15:8]);
    frm.push_back(LPORT[7:0]);
    frm.push_back(ulen[15:8]);
    frm.push_back(ulen[7:0]);
    repeat (2) frm.push_back(8'h00);
    foreach (pay[i]) frm.push_back(pay[i]);
    repeat (npad) frm.push_back(8'h00);
    frm.push_back(8'h11);
    frm.push_back(8'h22);
    frm.push_back(8'h33);
    frm.push_back(8'h44);
  endtask

  task automatic send(input int cut, input int gap);
    for (int i = 0; i < frm.size(); i++) begin
      if (i == cut) break;
      @(posedge clk); #1;
      rx_dv = 1'b1;
      rx_data = frm[i];
    end
    @(posedge clk); #1;
    rx_dv = 1'b0;
    rx_data = 8'h00;
    repeat (gap - 1) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic expect_pay(input int n);
    for (int i = 0; i < n; i++)
      sb.push_back({pay[i], (i == n - 1), 1'b0});
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    n_checks++;
    if ({axis.tvalid, axis.tlast, axis.tuser, axis.tdata} !== 11'd0) begin
      n_fail++;
      $display("FAIL reset_axis got=%b%b%b %h exp=0",
               axis.tvalid, axis.tlast, axis.tuser, axis.tdata);
    end
    n_checks++;
    if ({hdr_valid, frame_drop, src_mac, src_ip, src_port, udp_len} !== '0) begin
      n_fail++;
      $display("FAIL reset_hdr got=%b %b %h %h %h %h exp=0",
               hdr_valid, frame_drop, src_mac, src_ip, src_port, udp_len);
    end
  endtask

  task automatic finish_frame(input string nm, input int dh, input int dd,
                              input int h0, input int d0);
    repeat (4) @(posedge clk);
    #1;
    n_checks++;
    if (sb.size() !== 0) begin
      n_fail++;
      $display("FAIL %s_beats_left got=%0d exp=0", nm, sb.size());
      sb.delete();
    end
    n_checks++;
    if (hdr_cnt - h0 !== dh) begin
      n_fail++;
      $display("FAIL %s_hdr_pulses got=%0d exp=%0d", nm, hdr_cnt - h0, dh);
    end
    n_checks++;
    if (drop_cnt - d0 !== dd) begin
      n_fail++;
      $display("FAIL %s_drop_pulses got=%0d exp=%0d", nm, drop_cnt - d0, dd);
    end
  endtask

  task automatic test_nominal;
    int h0, d0;
    h0 = hdr_cnt; d0 = drop_cnt;
    pay = '{8'hDE, 8'hAD, 8'hBE, 8'hEF};
    exp_len = 16'h000C;
    build(LMAC, 16'h0800, LIP, 16'h000C, 0);
    expect_pay(4);
    send(-1, 3);
    finish_frame("nominal", 1, 0, h0, d0);
  endtask

  task automatic test_ip_mismatch;
    int h0, d0;
    h0 = hdr_cnt; d0 = drop_cnt;
    pay = '{8'hDE, 8'hAD, 8'hBE, 8'hEF};
    build(LMAC, 16'h0800, 32'hC0A8_010B, 16'h000C, 0);
    send(-1, 3);
    finish_frame("ip_mismatch", 0, 1, h0, d0);
    test_nominal();
  endtask

  task automatic test_ethertype_bcast;
    int h0, d0;
    h0 = hdr_cnt; d0 = drop_cnt;
    pay = '{8'h01, 8'h02, 8'h03};
    build(LMAC, 16'h0806, LIP, 16'h000B, 0);
    send(-1, 3);
    finish_frame("arp_type", 0, 1, h0, d0);
    h0 = hdr_cnt; d0 = drop_cnt;
    exp_len = 16'h000B;
    build(48'hFFFF_FFFF_FFFF, 16'h0800, LIP, 16'h000B, 0);
    expect_pay(3);
    send(-1, 3);
    finish_frame("broadcast", 1, 0, h0, d0);
  endtask

  task automatic test_udp_len;
    int h0, d0;
    h0 = hdr_cnt; d0 = drop_cnt;
    pay.delete();
    build(LMAC, 16'h0800, LIP, 16'h0008, 18);
    send(-1, 3);
    finish_frame("len8", 0, 1, h0, d0);
    h0 = hdr_cnt; d0 = drop_cnt;
    pay = '{8'h5A};
    exp_len = 16'h0009;
    build(LMAC, 16'h0800, LIP, 16'h0009, 17);
    expect_pay(1);
    send(-1, 3);
    finish_frame("len9_min", 1, 0, h0, d0);
  endtask

  task automatic test_early_end;
    int h0, d0;
    h0 = hdr_cnt; d0 = drop_cnt;
    pay = '{8'hDE, 8'hAD, 8'hBE, 8'hEF};
    exp_len = 16'h000C;
    build(LMAC, 16'h0800, LIP, 16'h000C, 0);
    sb.push_back({8'hDE, 1'b0, 1'b0});
    sb.push_back({8'hAD, 1'b0, 1'b0});
    sb.push_back({8'h00, 1'b1, 1'b1});
    send(52, 3);
    finish_frame("early_end", 1, 0, h0, d0);
  endtask

  task automatic test_reset_mid;
    int h0, d0;
    h0 = hdr_cnt; d0 = drop_cnt;
    pay = '{8'hDE, 8'hAD, 8'hBE, 8'hEF};
    exp_len = 16'h000C;
    build(LMAC, 16'h0800, LIP, 16'h000C, 0);
    sb.push_back({8'hDE, 1'b0, 1'b0});
    sb.push_back({8'hAD, 1'b0, 1'b0});
    for (int i = 0; i < frm.size(); i++) begin
      @(posedge clk); #1;
      if (i == 53) begin
        rst = 1'b0;
        n_checks++;
        if ({axis.tvalid, axis.tlast, axis.tuser, axis.tdata,
             hdr_valid, frame_drop, src_mac, src_ip} !== '0) begin
          n_fail++;
          $display("FAIL reset_mid_outputs got=%b %h %h %h exp=0",
                   axis.tvalid, axis.tdata, src_mac, src_ip);
        end
      end
      if (i == 52) rst = 1'b1;
      rx_dv = 1'b1;
      rx_data = frm[i];
    end
    @(posedge clk); #1;
    rx_dv = 1'b0;
    rx_data = 8'h00;
    repeat (2) @(posedge clk);
    finish_frame("reset_mid", 1, 0, h0, d0);
    test_nominal();
  endtask

  task automatic test_back_to_back;
    int h0, d0;
    h0 = hdr_cnt; d0 = drop_cnt;
    exp_len = 16'h000A;
    pay = '{8'hC3, 8'h3C};
    build(LMAC, 16'h0800, LIP, 16'h000A, 0);
    expect_pay(2);
    send(-1, 1);
    pay = '{8'h77, 8'h88};
    build(LMAC, 16'h0800, LIP, 16'h000A, 0);
    expect_pay(2);
    send(-1, 3);
    finish_frame("back_to_back", 2, 0, h0, d0);
  endtask

  initial begin
    test_reset();
    test_nominal();
    test_ip_mismatch();
    test_ethertype_bcast();
    test_udp_len();
    test_early_end();
    test_reset_mid();
    test_back_to_back();
    repeat (2) @(posedge clk);
    n_checks += m_checks;
    n_fail += m_fail;
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

endmodule
